// File: rtl/kgd_pkg.sv
// Shared constants for the KGD fill engine: KGD register map, CSR bit positions,
// slave register selects and the fill FSM encoding.
package kgd_pkg;

  localparam int AW_DEF = 14;

  localparam logic [2:0] KGD_CSR  = 3'b000;
  localparam logic [2:0] KGD_DATA = 3'b010;
  localparam logic [2:0] KGD_ADDR = 3'b100;
  localparam logic [2:0] KGD_CNT  = 3'b110;

  localparam int CSR_GO    = 0;
  localparam int CSR_ABORT = 1;
  localparam int CSR_IE    = 6;
  localparam int CSR_DONE  = 7;

  // Slave register select, taken from wb_adr_i[2:1]
  localparam logic [1:0] RSEL_CSR   = 2'b00;
  localparam logic [1:0] RSEL_ADDR  = 2'b01;
  localparam logic [1:0] RSEL_COUNT = 2'b10;
  localparam logic [1:0] RSEL_FILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETA,
    ST_WAITA,
    ST_SETD,
    ST_WAITD,
    ST_NEXT,
    ST_FIN
  } state_t;

endpackage

// File: rtl/kgd_fill_if.sv
// Classic Wishbone bundle; one instance is the CPU slave bus, another the KGD master bus.
interface kgd_fill_if;
  logic [2:0]  adr;
  logic [15:0] dat_w;
  logic [15:0] dat_r;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [1:0]  sel;
  logic        ack;

  // KGD is write-only from the engine's point of view, so the master side has no read data
  modport master (output adr, dat_w, cyc, stb, we, sel, input ack);
  modport slave  (input adr, dat_w, cyc, stb, we, sel, output dat_r, ack);
endinterface

// File: rtl/kgd_fill_regs.sv
// Slave register file (CSR/ADDR/COUNT/FILL) with single-cycle ack, plus
// address/count stepping and DONE/irq bookkeeping driven by the fill FSM.
module kgd_fill_regs
  import kgd_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  kgd_fill_if.slave     wb,
  input  logic          busy,
  input  logic          adv,
  input  logic          set_done,
  output logic          go,
  output logic          abort,
  output logic [AW-1:0] areg,
  output logic [AW-1:0] cnt,
  output logic [7:0]    fill,
  output logic          irq
);

  logic        ack_q;
  logic        ie;
  logic        done;
  logic [15:0] rdat;
  logic [15:0] rdat_q;
  logic        req;
  logic        wr;
  logic        csr_wr;
  logic        addr_wr;
  logic        cnt_wr;
  logic        fill_wr;
  logic        unused_bits;

  assign req     = wb.cyc & wb.stb & ~ack_q;
  assign wr      = req & wb.we;
  assign csr_wr  = wr & (wb.adr[2:1] == RSEL_CSR);
  assign addr_wr = wr & (wb.adr[2:1] == RSEL_ADDR) & ~busy;
  assign cnt_wr  = wr & (wb.adr[2:1] == RSEL_COUNT) & ~busy;
  assign fill_wr = wr & (wb.adr[2:1] == RSEL_FILL) & ~busy;

  // ABORT beats GO when both arrive in the same write
  assign go    = csr_wr & wb.sel[0] & wb.dat_w[CSR_GO] & ~wb.dat_w[CSR_ABORT] & ~busy;
  assign abort = csr_wr & wb.sel[0] & wb.dat_w[CSR_ABORT];

  assign wb.ack   = ack_q;
  assign wb.dat_r = rdat_q;

  assign unused_bits = &{1'b0, wb.adr[0], wb.dat_w[15:AW]};

  always_comb begin
    rdat = '0;
    case (wb.adr[2:1])
      RSEL_CSR:   rdat = {8'h00, done, ie, 5'b00000, busy};
      RSEL_ADDR:  rdat = 16'(areg);
      RSEL_COUNT: rdat = 16'(cnt);
      default:    rdat = {8'h00, fill};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
      areg   <= '0;
      cnt    <= '0;
      fill   <= '0;
      ie     <= 1'b0;
      done   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      ack_q  <= req;
      rdat_q <= (req & ~wb.we) ? rdat : '0;
      irq    <= done & ie;

      if (addr_wr) begin
        if (wb.sel[0]) areg[7:0]    <= wb.dat_w[7:0];
        if (wb.sel[1]) areg[AW-1:8] <= wb.dat_w[AW-1:8];
      end else if (adv) begin
        areg <= areg + 1'b1;
      end

      if (cnt_wr) begin
        if (wb.sel[0]) cnt[7:0]    <= wb.dat_w[7:0];
        if (wb.sel[1]) cnt[AW-1:8] <= wb.dat_w[AW-1:8];
      end else if (adv) begin
        cnt <= cnt - 1'b1;
      end

      if (fill_wr && wb.sel[0]) fill <= wb.dat_w[7:0];
      if (csr_wr && wb.sel[0])  ie   <= wb.dat_w[CSR_IE];

      if (set_done)    done <= 1'b1;
      else if (csr_wr) done <= 1'b0;
    end
  end

endmodule

// File: rtl/kgd_fill.sv
// Wishbone fill engine: writes the KGD address register then data register
// for every byte of a CPU-programmed run.
//
// state | meaning
// IDLE  | waiting for GO
// SETA  | load master bus with KGD address-register write
// WAITA | address write in flight, wait for ack
// SETD  | bus idle gap, load master bus with KGD data-register write
// WAITD | data write in flight, wait for ack
// NEXT  | step address/count, decide continue or finish
// FIN   | raise DONE
module kgd_fill
  import kgd_pkg::*;
#(
  parameter int         AW       = AW_DEF,
  parameter logic [2:0] KGD_AREG = KGD_ADDR,
  parameter logic [2:0] KGD_DREG = KGD_DATA
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n,
  kgd_fill_if.slave  wb,
  kgd_fill_if.master m,
  output logic       irq
);

  state_t        state;
  state_t        state_nx;
  logic          go;
  logic          abort;
  logic          abort_q;
  logic          abort_any;
  logic          busy;
  logic          load_a;
  logic          load_d;
  logic          drop;
  logic [AW-1:0] areg;
  logic [AW-1:0] cnt;
  logic [7:0]    fill;

  assign busy      = (state != ST_IDLE);
  assign abort_any = abort_q | abort;

  kgd_fill_regs #(.AW(AW)) u_regs (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n),
    .wb       (wb),
    .busy     (busy),
    .adv      (state == ST_NEXT),
    .set_done (state == ST_FIN),
    .go       (go),
    .abort    (abort),
    .areg     (areg),
    .cnt      (cnt),
    .fill     (fill),
    .irq      (irq)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state   <= ST_IDLE;
      abort_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE) abort_q <= 1'b0;
      else if (abort)       abort_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    load_a   = 1'b0;
    load_d   = 1'b0;
    drop     = 1'b0;
    case (state)
      ST_IDLE:  if (go) state_nx = (cnt == '0) ? ST_FIN : ST_SETA;
      ST_SETA:  begin
        if (abort_any) state_nx = ST_FIN;
        else begin
          load_a   = 1'b1;
          state_nx = ST_WAITA;
        end
      end
      ST_WAITA: if (m.ack) begin
        drop     = 1'b1;
        state_nx = abort_any ? ST_FIN : ST_SETD;
      end
      ST_SETD:  begin
        if (abort_any) state_nx = ST_FIN;
        else begin
          load_d   = 1'b1;
          state_nx = ST_WAITD;
        end
      end
      ST_WAITD: if (m.ack) begin
        drop     = 1'b1;
        state_nx = abort_any ? ST_FIN : ST_NEXT;
      end
      ST_NEXT:  state_nx = (abort_any || cnt == AW'(1)) ? ST_FIN : ST_SETA;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Strobe is only raised from a SET state, so back-to-back cycles always get an idle gap
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      m.cyc   <= 1'b0;
      m.stb   <= 1'b0;
      m.we    <= 1'b0;
      m.adr   <= '0;
      m.dat_w <= '0;
      m.sel   <= '0;
    end else if (load_a) begin
      m.cyc   <= 1'b1;
      m.stb   <= 1'b1;
      m.we    <= 1'b1;
      m.adr   <= KGD_AREG;
      m.dat_w <= 16'(areg);
      m.sel   <= 2'b11;
    end else if (load_d) begin
      m.cyc   <= 1'b1;
      m.stb   <= 1'b1;
      m.we    <= 1'b1;
      m.adr   <= KGD_DREG;
      m.dat_w <= {8'h00, fill};
      m.sel   <= 2'b01;
    end else if (drop) begin
      m.cyc <= 1'b0;
      m.stb <= 1'b0;
      m.we  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kgd_fill.sv
// Scoreboard bench for kgd_fill: directed CPU programming, a 2-cycle-ack KGD model,
// and a monitor that pops expected KGD writes and CPU read data as they appear.
module tb_kgd_fill;

  localparam logic [2:0] R_CSR = 3'b000, R_ADDR = 3'b010, R_CNT = 3'b100, R_FILL = 3'b110;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  logic seen;
  int   n_vec = 0, n_err = 0, n_mwr = 0, n_dack = 0;
  int   snap, base;
  logic [21:0] exp_m[$];
  logic [23:0] exp_r[$];
  logic [23:0] e_rd;
  logic [7:0]  rd_id = 8'd0;

  kgd_fill_if cpu ();
  kgd_fill_if kgd ();

  always #5 clk = ~clk;

  kgd_fill dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .wb       (cpu),
    .m        (kgd),
    .irq      (irq)
  );

  // KGD model: ack in the second cycle of strobe, single-cycle ack
  assign kgd.dat_r = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen    <= 1'b0;
      kgd.ack <= 1'b0;
    end else begin
      seen    <= kgd.stb & ~kgd.ack;
      kgd.ack <= kgd.stb & ~kgd.ack & seen;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && kgd.cyc && kgd.stb && kgd.ack) begin
      n_mwr++;
      if (kgd.adr == 3'b010) n_dack++;
      if (exp_m.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mwr_extra: got adr %0d dat %h expected no master write", kgd.adr, kgd.dat_w);
      end else begin
        check("mwr", {kgd.we, kgd.adr, kgd.sel, kgd.dat_w}, exp_m.pop_front());
      end
    end
    if (rst_n && cpu.cyc && cpu.ack && !cpu.we) begin
      if (exp_r.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_extra: got %h expected no read", cpu.dat_r);
      end else begin
        e_rd = exp_r.pop_front();
        check($sformatf("rd%0d", e_rd[23:16]), cpu.dat_r, e_rd[15:0]);
      end
    end
  end

  task automatic push_byte(input logic [13:0] a, input logic [7:0] f);
    exp_m.push_back({1'b1, 3'b100, 2'b11, 2'b00, a});
    exp_m.push_back({1'b1, 3'b010, 2'b01, 8'h00, f});
  endtask

  task automatic wb_cycle(input logic [2:0] a, input logic [15:0] d, input logic w, input logic [1:0] s);
    @(posedge clk); #1;
    cpu.adr = a; cpu.dat_w = d; cpu.we = w; cpu.sel = s; cpu.cyc = 1'b1; cpu.stb = 1'b1;
    for (int i = 0; i < 8 && !cpu.ack; i++) begin
      @(posedge clk); #1;
    end
    check("wb_ack", cpu.ack, 1);
    @(negedge clk); #1;
    cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] s = 2'b11);
    wb_cycle(a, d, 1'b1, s);
  endtask

  task automatic wb_read(input logic [2:0] a, input logic [15:0] expv);
    rd_id = rd_id + 8'd1;
    exp_r.push_back({rd_id, expv});
    wb_cycle(a, 16'h0000, 1'b0, 2'b11);
  endtask

  task automatic wait_irq(input int bound);
    for (int i = 0; i < bound && irq !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("irq_rise", irq, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cpu.adr = '0; cpu.dat_w = '0; cpu.we = 1'b0; cpu.sel = '0; cpu.cyc = 1'b0; cpu.stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {kgd.cyc, kgd.stb, kgd.we, irq, cpu.ack}, 0);
    check("rst_mbus", {kgd.adr, kgd.sel, kgd.dat_w}, 0);
    @(negedge clk) rst_n = 1'b1;
    wb_read(R_CSR, 16'h0000);
    wb_read(R_ADDR, 16'h0000);
    wb_read(R_CNT, 16'h0000);
    wb_read(R_FILL, 16'h0000);

    // basic 3-byte fill with interrupt
    wb_write(R_ADDR, 16'h0010);
    wb_write(R_CNT, 16'h0003);
    wb_write(R_FILL, 16'h00A5);
    push_byte(14'h0010, 8'hA5);
    push_byte(14'h0011, 8'hA5);
    push_byte(14'h0012, 8'hA5);
    wb_write(R_CSR, 16'h0041);
    wait_irq(200);
    wb_read(R_ADDR, 16'h0013);
    wb_read(R_CNT, 16'h0000);
    wb_read(R_CSR, 16'h00C0);
    wb_write(R_CSR, 16'h0040);
    repeat (2) @(posedge clk);
    #1 check("irq_clr1", irq, 0);
    wb_read(R_CSR, 16'h0040);

    // zero count: DONE without any master cycle, no irq with IE=0
    snap = n_mwr;
    wb_write(R_CNT, 16'h0000);
    wb_write(R_CSR, 16'h0001);
    wb_read(R_CSR, 16'h0080);
    repeat (5) @(posedge clk);
    #1 check("irq_ie0", irq, 0);
    check("zero_cnt_mwr", n_mwr - snap, 0);

    // address wrap
    wb_write(R_ADDR, 16'h3FFF);
    wb_write(R_CNT, 16'h0002);
    wb_write(R_FILL, 16'h003C);
    push_byte(14'h3FFF, 8'h3C);
    push_byte(14'h0000, 8'h3C);
    wb_write(R_CSR, 16'h0041);
    wait_irq(200);
    wb_read(R_ADDR, 16'h0001);
    wb_read(R_CNT, 16'h0000);
    wb_write(R_CSR, 16'h0000);

    // abort while an address cycle is in flight
    wb_write(R_ADDR, 16'h0100);
    wb_write(R_CNT, 16'd100);
    wb_write(R_FILL, 16'h0077);
    for (int b = 0; b < 5; b++) push_byte(14'h0100 + 14'(b), 8'h77);
    exp_m.push_back({1'b1, 3'b100, 2'b11, 16'h0105});
    base = n_dack;
    wb_write(R_CSR, 16'h0041);
    for (int i = 0; i < 300 && n_dack - base < 5; i++) begin
      @(posedge clk); #1;
    end
    check("dack5", n_dack - base, 5);
    @(posedge clk);
    wb_write(R_CSR, 16'h0042);
    wait_irq(100);
    wb_read(R_CNT, 16'h005F);
    wb_read(R_ADDR, 16'h0105);
    wb_read(R_CSR, 16'h00C0);
    snap = n_mwr;
    repeat (30) @(posedge clk);
    #1 check("abort_quiet", n_mwr - snap, 0);

    // GO together with ABORT while idle starts nothing
    wb_write(R_CSR, 16'h0003);
    repeat (20) @(posedge clk);
    #1 check("goabort_mwr", n_mwr - snap, 0);
    wb_read(R_CSR, 16'h0000);

    // register writes and GO while busy are ignored
    wb_write(R_ADDR, 16'h0200);
    wb_write(R_CNT, 16'h0002);
    wb_write(R_FILL, 16'h0011);
    push_byte(14'h0200, 8'h11);
    push_byte(14'h0201, 8'h11);
    wb_write(R_CSR, 16'h0041);
    wb_write(R_ADDR, 16'h1234);
    wb_write(R_CNT, 16'h0005);
    wb_write(R_CSR, 16'h0041);
    wait_irq(200);
    wb_read(R_ADDR, 16'h0202);
    wb_read(R_CNT, 16'h0000);
    wb_write(R_CSR, 16'h0040);
    repeat (2) @(posedge clk);
    #1 check("irq_clr2", irq, 0);
    wb_read(R_CSR, 16'h0040);

    // asynchronous reset during the data-register write
    wb_write(R_ADDR, 16'h0300);
    wb_write(R_CNT, 16'h0004);
    wb_write(R_FILL, 16'h0099);
    exp_m.push_back({1'b1, 3'b100, 2'b11, 16'h0300});
    wb_write(R_CSR, 16'h0001);
    for (int i = 0; i < 100 && !(kgd.cyc && kgd.adr == 3'b010); i++) begin
      @(posedge clk); #1;
    end
    check("waitd_reach", {kgd.cyc, kgd.adr}, {1'b1, 3'b010});
    #2 rst_n = 1'b0;
    #1 check("rst_async", {kgd.cyc, kgd.stb}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wb_read(R_CSR, 16'h0000);
    wb_read(R_ADDR, 16'h0000);
    wb_read(R_CNT, 16'h0000);
    wb_read(R_FILL, 16'h0000);
    check("irq_rst", irq, 0);

    // byte lanes
    wb_write(R_ADDR, 16'h2A55, 2'b10);
    wb_read(R_ADDR, 16'h2A00);
    wb_write(R_ADDR, 16'hFF11, 2'b01);
    wb_read(R_ADDR, 16'h2A11);

    repeat (5) @(posedge clk);
    check("mq_empty", exp_m.size(), 0);
    check("rq_empty", exp_r.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
